// File: rtl/leds_nios2_cpu_ocimem_ctrl_if.sv
// Debug-memory port bundle: JTAG-side strobes/readback and CPU-side Avalon-MM slave.
// No storage; the controller owns all latency and backpressure through waitrequest.
// master drives requests (sysclk stage / CPU), slave is the memory controller.
interface leds_nios2_cpu_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest, MonDReg, monitor_ready, monitor_error
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest, MonDReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/leds_nios2_cpu_ocimem_ctrl.sv
// Single-port debug RAM shared by JTAG (priority) and a CPU Avalon-MM slave.
// Latency: CPU write 1 cycle, CPU read 2 cycles, JTAG write/read done 2/3 cycles after strobe.
// Backpressure: waitrequest stalls the CPU while JTAG is pending; overrunning strobes are dropped.
module leds_nios2_cpu_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    leds_nios2_cpu_ocimem_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, J_RD, J_WR, C_RD} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              jrd_pend, jwr_pend;
    logic              rd_phase;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [31:0]       jwr_data;
    logic [31:0]       mon_d_reg;
    logic [31:0]       readdata_q;
    logic              monitor_ready_q, monitor_error_q;

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_we;
    logic              wait_req;

    logic any_strobe, busy, accept;
    assign any_strobe = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                        bus.take_no_action_ocimem_a;
    assign busy       = jrd_pend | jwr_pend;
    assign accept     = any_strobe & ~busy;

    always_comb begin
        state_d   = state_q;
        ram_addr  = mon_a_reg;
        ram_wdata = jwr_data;
        ram_we    = 4'b0000;
        wait_req  = 1'b1;
        case (state_q)
            IDLE: begin
                if (jwr_pend) begin
                    state_d = J_WR;
                end else if (jrd_pend) begin
                    state_d = J_RD;
                end else if (!any_strobe) begin
                    // A same-cycle strobe takes the RAM next cycle, so the CPU waits.
                    if (bus.write) begin
                        ram_addr  = bus.address;
                        ram_wdata = bus.writedata;
                        ram_we    = bus.byteenable;
                        wait_req  = 1'b0;
                    end else if (bus.read) begin
                        ram_addr = bus.address;
                        state_d  = C_RD;
                    end
                end
            end
            J_WR: begin
                ram_we  = 4'b1111;
                state_d = IDLE;
            end
            J_RD: begin
                if (rd_phase) state_d = IDLE;
            end
            C_RD: begin
                wait_req = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset forces IDLE asynchronously; also block any write launched from the CPU port.
        if (!reset_n) ram_we = 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            jrd_pend        <= 1'b0;
            jwr_pend        <= 1'b0;
            rd_phase        <= 1'b0;
            mon_a_reg       <= '0;
            jwr_data        <= '0;
            mon_d_reg       <= '0;
            readdata_q      <= '0;
            monitor_ready_q <= 1'b0;
            monitor_error_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_phase <= (state_q == J_RD) ? ~rd_phase : 1'b0;

            if (accept) begin
                monitor_ready_q <= 1'b0;
                if (bus.take_action_ocimem_a) begin
                    mon_a_reg       <= bus.jdo[ADDR_W+16:17];
                    jrd_pend        <= bus.jdo[35];
                    monitor_error_q <= 1'b0;
                end else if (bus.take_action_ocimem_b) begin
                    jwr_data <= bus.jdo[34:3];
                    jwr_pend <= 1'b1;
                end else begin
                    mon_a_reg <= mon_a_reg + ADDR_ONE;
                    jrd_pend  <= 1'b1;
                end
            end else if (any_strobe) begin
                monitor_error_q <= 1'b1;
            end

            if (state_q == J_WR) begin
                jwr_pend        <= 1'b0;
                mon_a_reg       <= mon_a_reg + ADDR_ONE;
                monitor_ready_q <= 1'b1;
            end
            if (state_q == J_RD && rd_phase) begin
                mon_d_reg       <= ram_q;
                jrd_pend        <= 1'b0;
                monitor_ready_q <= 1'b1;
            end
            if (state_q == C_RD) readdata_q <= ram_q;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
        ram_q <= mem[ram_addr];
    end

    // RAM output is presented directly in the C_RD cycle so readdata is valid while waitrequest is low.
    assign bus.readdata      = (state_q == C_RD) ? ram_q : readdata_q;
    assign bus.waitrequest   = wait_req;
    assign bus.MonDReg       = mon_d_reg;
    assign bus.monitor_ready = monitor_ready_q;
    assign bus.monitor_error = monitor_error_q;

    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{bus.jdo[37:36], bus.jdo[2:0]};
endmodule

// File: tb/tb_leds_nios2_cpu_ocimem_ctrl.sv
// Directed bench: stimulus pushes expected CPU readdata / JTAG MonDReg into queues,
// a negedge monitor pops and compares whenever the DUT completes a transfer.
module tb_leds_nios2_cpu_ocimem_ctrl;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    leds_nios2_cpu_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    leds_nios2_cpu_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] jtag_q[$];
    logic [31:0] exp_mon_d = 32'h0;
    logic        prev_ready = 1'b0;
    int          cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: CPU read completes on read && !waitrequest; JTAG op completes on monitor_ready rise.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.read && !bus.waitrequest) begin
                if (cpu_q.size() == 0) check("cpu_unexpected_read", 32'd1, 32'd0);
                else check("cpu_readdata", bus.readdata, cpu_q.pop_front());
            end
            if (bus.monitor_ready && !prev_ready) begin
                if (jtag_q.size() == 0) check("jtag_unexpected_ready", 32'd1, 32'd0);
                else check("jtag_MonDReg", bus.MonDReg, jtag_q.pop_front());
            end
        end
        prev_ready = bus.monitor_ready;
    end

    function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[35] = rd;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // kind: 0 = take_action_ocimem_a, 1 = take_action_ocimem_b, 2 = take_no_action_ocimem_a
    task automatic strobe(input int kind, input logic [37:0] j);
        @(posedge clk); #1;
        bus.jdo = j;
        bus.take_action_ocimem_a    = (kind == 0);
        bus.take_action_ocimem_b    = (kind == 1);
        bus.take_no_action_ocimem_a = (kind == 2);
        @(posedge clk); #1;
        bus.take_action_ocimem_a    = 1'b0;
        bus.take_action_ocimem_b    = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bit done = 0;
        @(posedge clk); #1;
        bus.address = a; bus.writedata = d; bus.byteenable = be; bus.write = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.waitrequest) begin done = 1; break; end
        end
        if (!done) check("cpu_write_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp, output int cycles);
        bit done = 0;
        cpu_q.push_back(exp);
        cycles = 0;
        @(posedge clk); #1;
        bus.address = a; bus.read = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cycles++;
            if (!bus.waitrequest) begin done = 1; break; end
        end
        if (!done) begin
            check("cpu_read_timeout", 32'd0, 32'd1);
            cpu_q.delete();
        end
        @(posedge clk); #1;
        bus.read = 1'b0;
    endtask

    // Counts posedges until the monitor has drained the JTAG queue (the pop happens on the
    // negedge before the counted posedge).
    task automatic wait_jtag(output int cycles);
        bit done = 0;
        cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            cycles++;
            if (jtag_q.size() == 0) begin done = 1; break; end
        end
        if (!done) begin
            check("jtag_timeout", 32'd0, 32'd1);
            jtag_q.delete();
        end
        #1;
    endtask

    initial begin
        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
        bus.writedata = '0; bus.byteenable = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readdata",      bus.readdata,      32'h0);
        check("rst_MonDReg",       bus.MonDReg,       32'h0);
        check("rst_monitor_ready", bus.monitor_ready, 32'h0);
        check("rst_monitor_error", bus.monitor_error, 32'h0);
        check("rst_waitrequest",   bus.waitrequest,   32'h1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // JTAG write 0xDEADBEEF to 0x10, then read it back
        strobe(0, jdo_addr(8'h10, 1'b0));
        jtag_q.push_back(exp_mon_d);
        strobe(1, jdo_data(32'hDEADBEEF));
        wait_jtag(cyc);
        check("jwr_latency", cyc, 32'd3);
        check("jwr_MonAReg_inc", {24'h0, dut.mon_a_reg}, 32'h11);
        check("jwr_monitor_ready", bus.monitor_ready, 32'h1);
        exp_mon_d = 32'hDEADBEEF;
        jtag_q.push_back(exp_mon_d);
        strobe(0, jdo_addr(8'h10, 1'b1));
        wait_jtag(cyc);
        check("jrd_latency", cyc, 32'd4);
        check("jrd_monitor_ready", bus.monitor_ready, 32'h1);

        // Auto-increment wrap 0xFF -> 0x00
        cpu_write(8'hFF, 32'hA5A5A5A5, 4'hF);
        cpu_write(8'h00, 32'h5A5A5A5A, 4'hF);
        exp_mon_d = 32'hA5A5A5A5;
        jtag_q.push_back(exp_mon_d);
        strobe(0, jdo_addr(8'hFF, 1'b1));
        wait_jtag(cyc);
        exp_mon_d = 32'h5A5A5A5A;
        jtag_q.push_back(exp_mon_d);
        strobe(2, '0);
        wait_jtag(cyc);
        check("wrap_MonAReg", {24'h0, dut.mon_a_reg}, 32'h00);

        // CPU byte-lane write then read
        cpu_write(8'h20, 32'hFFFFFFFF, 4'hF);
        cpu_write(8'h20, 32'h11223344, 4'b0101);
        cpu_read(8'h20, 32'hFF22FF44, cyc);
        check("cpu_read_latency", cyc, 32'd2);
        cpu_read(8'h10, 32'hDEADBEEF, cyc);

        // Same-cycle JTAG write and CPU read: JTAG first, CPU sees new value
        strobe(0, jdo_addr(8'h30, 1'b0));
        jtag_q.push_back(exp_mon_d);
        fork
            strobe(1, jdo_data(32'hCAFEF00D));
            cpu_read(8'h30, 32'hCAFEF00D, cyc);
        join
        check("arb_cpu_stall_cycles", cyc, 32'd5);
        wait_jtag(cyc);

        // Overrun: second take_action_ocimem_a dropped while a read is pending
        cpu_write(8'h40, 32'h40404040, 4'hF);
        exp_mon_d = 32'h40404040;
        jtag_q.push_back(exp_mon_d);
        strobe(0, jdo_addr(8'h40, 1'b1));
        strobe(0, jdo_addr(8'h50, 1'b1));
        check("ovr_monitor_error", bus.monitor_error, 32'h1);
        check("ovr_MonAReg_kept", {24'h0, dut.mon_a_reg}, 32'h40);
        wait_jtag(cyc);
        check("ovr_error_sticky", bus.monitor_error, 32'h1);
        strobe(0, jdo_addr(8'h50, 1'b0));
        check("ovr_error_cleared", bus.monitor_error, 32'h0);
        check("ovr_MonAReg_new", {24'h0, dut.mon_a_reg}, 32'h50);

        // Reset during J_WR: target word must survive
        cpu_write(8'h60, 32'h12345678, 4'hF);
        strobe(0, jdo_addr(8'h60, 1'b0));
        strobe(1, jdo_data(32'hBAD0BAD0));
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_readdata",      bus.readdata,      32'h0);
        check("midrst_MonDReg",       bus.MonDReg,       32'h0);
        check("midrst_monitor_ready", bus.monitor_ready, 32'h0);
        check("midrst_monitor_error", bus.monitor_error, 32'h0);
        check("midrst_waitrequest",   bus.waitrequest,   32'h1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_mon_d = 32'h0;
        cpu_read(8'h60, 32'h12345678, cyc);
        check("postrst_read_latency", cyc, 32'd2);

        repeat (4) @(posedge clk);
        check("cpu_queue_drained",  cpu_q.size(),  32'd0);
        check("jtag_queue_drained", jtag_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
